// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: widths, size codes,
// FSM state codes and the requester identity type.
package mem_ctrl_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned WordW = 32;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRead   = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StIoWait = 2'd3;

  typedef enum logic {
    GrantIf = 1'b0,
    GrantLs = 1'b1
  } grant_e;

  // Number of byte beats for an access size; the illegal code 11 is handled as a word.
  function automatic logic [2:0] beats_for_size(input logic [1:0] size);
    case (size)
      SizeByte: beats_for_size = 3'd1;
      SizeHalf: beats_for_size = 3'd2;
      SizeWord: beats_for_size = 3'd4;
      default:  beats_for_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_asm.sv
// Inserts one RAM byte into its lane of a partially assembled 32-bit word.
module mem_ctrl_byte_asm
  import mem_ctrl_pkg::*;
(
  input  logic [WordW-1:0] word_i,
  input  logic [ByteW-1:0] byte_i,
  input  logic [1:0]       lane_i,
  output logic [WordW-1:0] word_o
);

  // OR the byte into lane_i; lanes not yet filled are zero.
  always_comb begin
    word_o = word_i | (WordW'(byte_i) << {lane_i, 3'b000});
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter between instruction fetch and the load/store unit.
// Each granted access is serialised into 1, 2 or 4 byte beats.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [1:0]  IO_BASE = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              io_buffer_full,
  input  logic [ByteW-1:0]  mem_din,
  output logic [ByteW-1:0]  mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [WordW-1:0]  if_data,
  input  logic              ls_valid,
  input  logic              ls_write,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [WordW-1:0]  ls_wdata,
  output logic              ls_done,
  output logic [WordW-1:0]  ls_rdata
);

  localparam int unsigned RestW = WordW - ByteW;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [RestW-1:0]  wdata_q, wdata_d;
  logic [ByteW-1:0]  mem_dout_q, mem_dout_d;
  grant_e            owner_q, owner_d;
  grant_e            last_grant_q, last_grant_d;
  logic [WordW-1:0]  buf_q, buf_d;
  logic [WordW-1:0]  if_data_q, if_data_d;
  logic [WordW-1:0]  ls_rdata_q, ls_rdata_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;

  logic [WordW-1:0]  asm_word;
  logic [1:0]        asm_lane;
  logic              can_grant, grant_if, grant_ls;

  // Beat j of a read samples the byte addressed in beat j-1.
  assign asm_lane = cnt_q[1:0] - 2'd1;

  mem_ctrl_byte_asm u_byte_asm (
    .word_i (buf_q),
    .byte_i (mem_din),
    .lane_i (asm_lane),
    .word_o (asm_word)
  );

  // Round-robin arbitration; no grant while a done pulse is still visible to its requester.
  always_comb begin
    can_grant = (state_q == StIdle) && !clear && !if_done_q && !ls_done_q;
    grant_ls  = 1'b0;
    grant_if  = 1'b0;
    if (can_grant) begin
      if (ls_valid && if_valid) begin
        grant_ls = (last_grant_q == GrantIf);
        grant_if = (last_grant_q == GrantLs);
      end else begin
        grant_ls = ls_valid;
        grant_if = if_valid;
      end
    end
  end

  // Controller next state; everything holds while rdy is low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    mem_a_d      = mem_a_q;
    wdata_d      = wdata_q;
    mem_dout_d   = mem_dout_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    buf_d        = buf_q;
    if_data_d    = if_data_q;
    ls_rdata_d   = ls_rdata_q;
    if_done_d    = if_done_q;
    ls_done_d    = ls_done_q;
    if (rdy) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_ls) begin
            owner_d      = GrantLs;
            last_grant_d = GrantLs;
            mem_a_d      = ls_addr;
            n_d          = beats_for_size(ls_size);
            cnt_d        = 3'd0;
            buf_d        = '0;
            if (ls_write) begin
              mem_dout_d = ls_wdata[ByteW-1:0];
              wdata_d    = ls_wdata[WordW-1:ByteW];
              state_d    = (ls_addr[17:16] == IO_BASE && io_buffer_full) ? StIoWait : StWrite;
            end else begin
              state_d = StRead;
            end
          end else if (grant_if) begin
            owner_d      = GrantIf;
            last_grant_d = GrantIf;
            mem_a_d      = if_addr;
            n_d          = beats_for_size(SizeWord);
            cnt_d        = 3'd0;
            buf_d        = '0;
            state_d      = StRead;
          end
        end
        StRead: begin
          if (clear) begin
            state_d = StIdle;
          end else begin
            if (cnt_q != 3'd0) buf_d = asm_word;
            if (cnt_q == n_q) begin
              state_d = StIdle;
              if (owner_q == GrantIf) begin
                if_done_d = 1'b1;
                if_data_d = asm_word;
              end else begin
                ls_done_d  = 1'b1;
                ls_rdata_d = asm_word;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q + 3'd1 < n_q) mem_a_d = mem_a_q + ADDR_W'(1);
            end
          end
        end
        // Stores are committed: clear does not abort them.
        StWrite: begin
          if (cnt_q + 3'd1 == n_q) begin
            state_d   = StIdle;
            ls_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            mem_a_d    = mem_a_q + ADDR_W'(1);
            mem_dout_d = wdata_q[ByteW-1:0];
            wdata_d    = {{ByteW{1'b0}}, wdata_q[RestW-1:ByteW]};
          end
        end
        StIoWait: begin
          if (!io_buffer_full) state_d = StWrite;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      n_q          <= 3'd0;
      mem_a_q      <= '0;
      wdata_q      <= '0;
      mem_dout_q   <= '0;
      owner_q      <= GrantIf;
      last_grant_q <= GrantIf;
      buf_q        <= '0;
      if_data_q    <= '0;
      ls_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      mem_a_q      <= mem_a_d;
      wdata_q      <= wdata_d;
      mem_dout_q   <= mem_dout_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      buf_q        <= buf_d;
      if_data_q    <= if_data_d;
      ls_rdata_q   <= ls_rdata_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
    end
  end

  assign mem_wr   = (state_q == StWrite) && rdy;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random loads, stores
// and fetches checked against a byte-array shadow of the RAM region.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_valid, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_valid, ls_write, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram [0:262143];
  logic [7:0] shadow [0:255];
  int wr_beats = 0;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_valid       (if_valid),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_valid       (ls_valid),
    .ls_write       (ls_write),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata)
  );

  always #5 clk = ~clk;

  // RAM: read byte appears the cycle after its address; frozen with the rest of the system.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      wr_beats <= wr_beats + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int beats(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; if_valid = 1'b0; ls_valid = 1'b0; clear = 1'b0;
    io_buffer_full = 1'b0; rdy = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst = 1'b0;
  endtask

  // One LS transaction; lat counts cycles from the request cycle to the done cycle (60 = none).
  task automatic run_ls(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int clr_at, input int lo_from,
                        input int lo_to, output logic [31:0] rd, output int lat,
                        output int wr_frozen);
    @(negedge clk);
    ls_valid = 1'b1; ls_write = wr; ls_size = sz; ls_addr = addr; ls_wdata = wd;
    clear = (clr_at == 0);
    lat = 0; rd = '0; wr_frozen = 0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      clear = (lat == clr_at);
      if (lat == clr_at && !wr) ls_valid = 1'b0;
      rdy = !(lat >= lo_from && lat <= lo_to);
      #1;
      if (!rdy && mem_wr) wr_frozen++;
      if (ls_done) begin
        rd = ls_rdata;
        break;
      end
    end
    ls_valid = 1'b0; clear = 1'b0; rdy = 1'b1;
  endtask

  task automatic run_if(input logic [31:0] addr, input int clr_at, input int lo_from,
                        input int lo_to, output logic [31:0] rd, output int lat);
    @(negedge clk);
    if_valid = 1'b1; if_addr = addr;
    lat = 0; rd = '0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      clear = (lat == clr_at);
      if (lat == clr_at) if_valid = 1'b0;
      rdy = !(lat >= lo_from && lat <= lo_to);
      #1;
      if (if_done) begin
        rd = if_data;
        break;
      end
    end
    if_valid = 1'b0; clear = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, a, wd, exp;
    logic [1:0]  sz;
    int lat, wf, b0, ls_left, if_left, off, n;
    int order[$];

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_valid = 1'b0; if_addr = '0; ls_valid = 1'b0; ls_write = 1'b0;
    ls_size = '0; ls_addr = '0; ls_wdata = '0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      shadow[i] = 8'($urandom);
      ram[32'h1000 + i] = shadow[i];
    end
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h41] = 8'hFF; ram[32'h42] = 8'h80;
    ram[32'h50] = 8'h9C;

    apply_reset();

    // Word fetch: done 6 cycles after grant.
    run_if(32'h100, -1, 0, -1, rd, lat);
    check("if_word_lat", 32'(lat), 32'd6);
    check("if_word_data", rd, 32'h00000513);

    // Byte store: a single write beat.
    b0 = wr_beats;
    run_ls(1'b1, 2'b00, 32'h20, 32'h000000AB, -1, 0, -1, rd, lat, wf);
    check("sb_lat", 32'(lat), 32'd2);
    check("sb_beats", 32'(wr_beats - b0), 32'd1);
    check("sb_ram", 32'(ram[32'h20]), 32'hAB);
    check("sb_ram_next_untouched", 32'(ram[32'h21]), 32'h00);

    // Clear aborts a fetch in progress.
    run_if(32'h100, 2, 0, -1, rd, lat);
    check("clear_if_no_done", 32'(lat), 32'd60);

    // Halfword load at odd address, zero-extended.
    run_ls(1'b0, 2'b01, 32'h41, 32'h0, -1, 0, -1, rd, lat, wf);
    check("lh_lat", 32'(lat), 32'd4);
    check("lh_data", rd, 32'h000080FF);

    // Clear in IDLE holds off the grant for one cycle.
    run_ls(1'b0, 2'b00, 32'h50, 32'h0, 0, 0, -1, rd, lat, wf);
    check("clear_idle_lat", 32'(lat), 32'd4);
    check("clear_idle_data", rd, 32'h0000009C);

    // Store completes despite clear mid-write.
    run_ls(1'b1, 2'b10, 32'h300, 32'h55667788, 2, 0, -1, rd, lat, wf);
    check("st_clear_lat", 32'(lat), 32'd5);
    check("st_clear_ram", {ram[32'h303], ram[32'h302], ram[32'h301], ram[32'h300]},
          32'h55667788);

    // IO store held while the UART buffer is full.
    @(negedge clk);
    ls_valid = 1'b1; ls_write = 1'b1; ls_size = 2'b10; ls_addr = 32'h30000;
    ls_wdata = 32'h11223344; io_buffer_full = 1'b1;
    b0 = wr_beats; lat = 0;
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    check("io_hold_no_wr", 32'(wr_beats - b0), 32'd0);
    io_buffer_full = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (ls_done) break;
    end
    ls_valid = 1'b0;
    check("io_lat", 32'(lat), 32'd10);
    check("io_beats", 32'(wr_beats - b0), 32'd4);
    check("io_ram", {ram[32'h30003], ram[32'h30002], ram[32'h30001], ram[32'h30000]},
          32'h11223344);

    // rdy low for 3 cycles mid-read: same data, 3 cycles later.
    run_if(32'h100, -1, 2, 4, rd, lat);
    check("rdy_if_lat", 32'(lat), 32'd9);
    check("rdy_if_data", rd, 32'h00000513);

    // rdy low mid-store: no write strobe while frozen.
    run_ls(1'b1, 2'b10, 32'h400, 32'hCAFEF00D, -1, 2, 4, rd, lat, wf);
    check("rdy_st_lat", 32'(lat), 32'd8);
    check("rdy_st_wr_frozen", 32'(wf), 32'd0);
    check("rdy_st_ram", {ram[32'h403], ram[32'h402], ram[32'h401], ram[32'h400]}, 32'hCAFEF00D);

    // Address wraps modulo 2^32.
    run_ls(1'b1, 2'b01, 32'hFFFFFFFF, 32'h00001234, -1, 0, -1, rd, lat, wf);
    check("wrap_lat", 32'(lat), 32'd3);
    check("wrap_lo", 32'(ram[18'h3FFFF]), 32'h34);
    check("wrap_hi", 32'(ram[0]), 32'h12);

    // Illegal size 11 behaves as a word.
    run_ls(1'b1, 2'b11, 32'h200, 32'hA1B2C3D4, -1, 0, -1, rd, lat, wf);
    check("size3_lat", 32'(lat), 32'd5);
    check("size3_ram", {ram[32'h203], ram[32'h202], ram[32'h201], ram[32'h200]}, 32'hA1B2C3D4);

    // Contention from reset: LS first, then strict alternation.
    apply_reset();
    @(negedge clk);
    ls_valid = 1'b1; ls_write = 1'b0; ls_size = 2'b00; ls_addr = 32'h1000;
    if_valid = 1'b1; if_addr = 32'h1004;
    ls_left = 3; if_left = 3;
    for (int cyc = 0; cyc < 200 && (ls_left > 0 || if_left > 0); cyc++) begin
      @(negedge clk);
      if (ls_done) begin
        check("arb_ls_data", ls_rdata, {24'h0, shadow[0]});
        order.push_back(0);
        ls_left--;
        ls_valid = 1'b0;
      end else begin
        ls_valid = (ls_left > 0);
      end
      if (if_done) begin
        check("arb_if_data", if_data, {shadow[7], shadow[6], shadow[5], shadow[4]});
        order.push_back(1);
        if_left--;
        if_valid = 1'b0;
      end else begin
        if_valid = (if_left > 0);
      end
    end
    ls_valid = 1'b0; if_valid = 1'b0;
    check("arb_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) check("arb_order", 32'(order[i]), 32'(i % 2));

    // Random mix inside the shadowed region.
    for (int i = 0; i < 60; i++) begin
      off = $urandom_range(0, 252);
      a = 32'h1000 + 32'(off);
      case ($urandom_range(0, 2))
        0: begin
          sz = 2'($urandom_range(0, 3));
          wd = $urandom;
          n = beats(sz);
          run_ls(1'b1, sz, a, wd, -1, 0, -1, rd, lat, wf);
          for (int k = 0; k < n; k++) shadow[off + k] = wd[8*k +: 8];
          check("rnd_st_lat", 32'(lat), 32'(n + 1));
        end
        1: begin
          sz = 2'($urandom_range(0, 1));
          n = beats(sz);
          exp = '0;
          for (int k = 0; k < n; k++) exp[8*k +: 8] = shadow[off + k];
          run_ls(1'b0, sz, a, 32'h0, -1, 0, -1, rd, lat, wf);
          check("rnd_ld_lat", 32'(lat), 32'(n + 2));
          check("rnd_ld_data", rd, exp);
        end
        default: begin
          exp = {shadow[off + 3], shadow[off + 2], shadow[off + 1], shadow[off]};
          run_if(a, -1, 0, -1, rd, lat);
          check("rnd_if_lat", 32'(lat), 32'd6);
          check("rnd_if_data", rd, exp);
        end
      endcase
    end

    for (int i = 0; i < 256; i++) check("rnd_ram_final", 32'(ram[32'h1000 + i]), 32'(shadow[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
